// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register and data-cache access sequencer.
// Holds the execute-stage result while a cache access is outstanding,
// back-pressures IF/ID/EX, runs an access watchdog and keeps a sticky err.
// Optional feature macro: EX_MEM_ALIGN_CHECK_EN. When defined, a misaligned
// memory op is suppressed at capture and raises err.
module ex_mem_pipe #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_XOut,
    input  logic [15:0] ex_WriteData,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic        ex_RegWrite,
    input  logic        ex_MemToReg,
    input  logic [2:0]  ex_WriteReg,
    input  logic        ex_halt,
    input  logic        flush,
    input  logic        DC_Stall,
    input  logic        DC_Done,
    input  logic        mem_err,
    output logic [15:0] XOut,
    output logic [15:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        createdump,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [2:0]  WriteReg,
    output logic        valid,
    output logic        stall_up,
    output logic        err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    // Saturating watchdog increment so the counter never wraps back to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic        load;
    logic        in_access;

    // Capture-side (p0) values presented by EX this cycle
    logic        vld_p0;
    logic        misalign_p0;
    logic        rd_p0, wr_p0, rw_p0, m2r_p0, dump_p0;
    logic        memop_p0;

    // Registered (p1) values presented to the memory stage
    logic        vld_p1;
    logic        rd_p1, wr_p1, rw_p1, m2r_p1, dump_p1;
    logic [15:0] xout_p1, wdata_p1;
    logic [2:0]  wreg_p1;
    logic        misalign_p1;

    logic [7:0]  wd_cnt;
    logic [7:0]  wd_inc;
    logic        wd_fire;
    logic        err_q;

    // DC_Stall is advisory only; the sequencer relies on DC_Done alone.
    logic        unused_dc_stall;
    assign unused_dc_stall = DC_Stall;

    assign in_access = (state_q == ACCESS);
    assign stall_up  = in_access & ~DC_Done;
    assign load      = ~stall_up;

    assign vld_p0 = ex_valid & ~flush;
`ifdef EX_MEM_ALIGN_CHECK_EN
    assign misalign_p0 = vld_p0 & (ex_MemRead | ex_MemWrite) & ex_XOut[0];
`else
    assign misalign_p0 = 1'b0;
`endif
    assign rd_p0    = vld_p0 & ex_MemRead  & ~misalign_p0;
    assign wr_p0    = vld_p0 & ex_MemWrite & ~misalign_p0;
    assign rw_p0    = vld_p0 & ex_RegWrite & ~misalign_p0;
    assign m2r_p0   = vld_p0 & ex_MemToReg;
    assign dump_p0  = vld_p0 & ex_halt;
    assign memop_p0 = rd_p0 | wr_p0;

    assign wd_inc  = sat_inc(wd_cnt);
    assign wd_fire = in_access & ~DC_Done & (wd_inc == TIMEOUT_W);

    // Next-state logic: every load edge re-decides based on what is captured.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = memop_p0 ? ACCESS : IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- p0 -> p1 stage boundary: capture EX on every load edge ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            rd_p1       <= 1'b0;
            wr_p1       <= 1'b0;
            rw_p1       <= 1'b0;
            m2r_p1      <= 1'b0;
            dump_p1     <= 1'b0;
            misalign_p1 <= 1'b0;
            xout_p1     <= 16'h0000;
            wdata_p1    <= 16'h0000;
            wreg_p1     <= 3'd0;
        end else if (load) begin
            vld_p1      <= vld_p0;
            rd_p1       <= rd_p0;
            wr_p1       <= wr_p0;
            rw_p1       <= rw_p0;
            m2r_p1      <= m2r_p0;
            dump_p1     <= dump_p0;
            misalign_p1 <= misalign_p0;
            xout_p1     <= ex_XOut;
            wdata_p1    <= ex_WriteData;
            wreg_p1     <= ex_WriteReg;
        end else begin
            // A misaligned op is flagged once, on the edge after capture.
            misalign_p1 <= 1'b0;
        end
    end

    // Watchdog: restart on entry to ACCESS, count cycles waiting for DC_Done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= 8'd0;
        end else if (load && memop_p0) begin
            wd_cnt <= 8'd0;
        end else if (in_access && !DC_Done) begin
            wd_cnt <= wd_inc;
        end
    end

    // Sticky error: memory-side error on a real instruction, timeout, misalign.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((mem_err && vld_p1) || wd_fire || misalign_p1) begin
            err_q <= 1'b1;
        end
    end

    assign XOut       = xout_p1;
    assign WriteData  = wdata_p1;
    assign MemRead    = rd_p1 & vld_p1;
    assign MemWrite   = wr_p1 & vld_p1;
    assign createdump = dump_p1 & vld_p1;
    assign RegWrite   = rw_p1 & vld_p1;
    assign MemToReg   = m2r_p1 & vld_p1;
    assign WriteReg   = wreg_p1;
    assign valid      = vld_p1;
    assign err        = err_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe (TIMEOUT=8).
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemToReg, ex_halt;
    logic [15:0] ex_XOut, ex_WriteData;
    logic [2:0]  ex_WriteReg;
    logic        flush, DC_Stall, DC_Done, mem_err;
    logic [15:0] XOut, WriteData;
    logic        MemRead, MemWrite, createdump, RegWrite, MemToReg, valid, stall_up, err;
    logic [2:0]  WriteReg;

    int checks = 0;
    int errors = 0;

    ex_mem_pipe #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_XOut(ex_XOut), .ex_WriteData(ex_WriteData),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
        .ex_WriteReg(ex_WriteReg), .ex_halt(ex_halt), .flush(flush),
        .DC_Stall(DC_Stall), .DC_Done(DC_Done), .mem_err(mem_err),
        .XOut(XOut), .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .createdump(createdump), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .WriteReg(WriteReg), .valid(valid), .stall_up(stall_up), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        ex_valid = 0; ex_MemRead = 0; ex_MemWrite = 0; ex_RegWrite = 0;
        ex_MemToReg = 0; ex_halt = 0; ex_XOut = 16'h0; ex_WriteData = 16'h0;
        ex_WriteReg = 3'd0; flush = 0;
    endtask

    task automatic pulse_reset();
        #2 rst = 0;
        #2 rst = 1;
        bubble();
        DC_Done = 0; mem_err = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 0; DC_Stall = 0; DC_Done = 1; mem_err = 1; flush = 0;
        ex_valid = 1; ex_MemRead = 1; ex_MemWrite = 1; ex_RegWrite = 1;
        ex_MemToReg = 1; ex_halt = 1; ex_XOut = 16'hA5A5; ex_WriteData = 16'h5A5A;
        ex_WriteReg = 3'd7;
        repeat (3) tick();
        checks++;
        if ({XOut, WriteData} !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h %h, required 0000 0000", XOut, WriteData);
        end
        checks++;
        if ({MemRead, MemWrite, createdump, RegWrite, MemToReg, valid, err, WriteReg} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rd%b wr%b dump%b rw%b m2r%b v%b err%b wreg%0d, required all 0",
                     MemRead, MemWrite, createdump, RegWrite, MemToReg, valid, err, WriteReg);
        end
        checks++;
        if (stall_up !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b, required 0", stall_up);
        end
        // release, then first load on the next rising edge
        rst = 1; mem_err = 0; DC_Done = 0;
        bubble();
        ex_valid = 1; ex_RegWrite = 1; ex_XOut = 16'h00AA; ex_WriteReg = 3'd2;
        tick();
        checks++;
        if ({valid, RegWrite, XOut, WriteReg} !== {1'b1, 1'b1, 16'h00AA, 3'd2}) begin
            errors++; $display("FAIL reset_first_load: got v%b rw%b x%h wreg%0d, required v1 rw1 x00aa wreg2",
                               valid, RegWrite, XOut, WriteReg);
        end
        bubble();
        tick();
    endtask

    task automatic test_hit_load();
        bubble();
        ex_valid = 1; ex_MemRead = 1; ex_MemToReg = 1; ex_RegWrite = 1;
        ex_XOut = 16'h0040; ex_WriteReg = 3'd3; DC_Done = 1;
        tick();
        checks++;
        if ({MemRead, XOut, stall_up, MemToReg} !== {1'b1, 16'h0040, 1'b0, 1'b1}) begin
            errors++; $display("FAIL hit_access: got rd%b x%h stall%b m2r%b, required rd1 x0040 stall0 m2r1",
                               MemRead, XOut, stall_up, MemToReg);
        end
        bubble();
        tick();
        DC_Done = 0;
        #1;
        checks++;
        if ({MemRead, valid, stall_up} !== 3'b000) begin
            errors++; $display("FAIL hit_return_idle: got rd%b v%b stall%b, required 000", MemRead, valid, stall_up);
        end
    endtask

    task automatic test_miss_store();
        bubble();
        ex_valid = 1; ex_MemWrite = 1; ex_XOut = 16'h0100; ex_WriteData = 16'hBEEF;
        DC_Done = 0;
        tick();
        // next instruction waits upstream during the stall
        bubble();
        ex_valid = 1; ex_RegWrite = 1; ex_XOut = 16'h1234; ex_WriteReg = 3'd5;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({stall_up, MemWrite, WriteData, XOut} !== {1'b1, 1'b1, 16'hBEEF, 16'h0100}) begin
                errors++; $display("FAIL miss_hold_c%0d: got stall%b wr%b wd%h x%h, required stall1 wr1 wdbeef x0100",
                                   i, stall_up, MemWrite, WriteData, XOut);
            end
            flush = (i == 2);
            tick();
        end
        flush = 0;
        DC_Done = 1;
        #1;
        checks++;
        if ({stall_up, MemWrite} !== 2'b01) begin
            errors++; $display("FAIL miss_done_cycle: got stall%b wr%b, required stall0 wr1", stall_up, MemWrite);
        end
        tick();
        DC_Done = 0;
        #1;
        checks++;
        if ({XOut, RegWrite, MemWrite, valid, stall_up, WriteReg} !== {16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5}) begin
            errors++; $display("FAIL miss_next_load: got x%h rw%b wr%b v%b stall%b wreg%0d, required x1234 rw1 wr0 v1 stall0 wreg5",
                               XOut, RegWrite, MemWrite, valid, stall_up, WriteReg);
        end
        bubble();
        tick();
    endtask

    task automatic test_flush();
        bubble();
        ex_valid = 1; ex_halt = 1;
        tick();
        checks++;
        if (createdump !== 1'b1) begin
            errors++; $display("FAIL halt_dump: got %b, required 1", createdump);
        end
        bubble();
        ex_valid = 1; ex_RegWrite = 1; ex_halt = 1; ex_XOut = 16'h5555; flush = 1;
        tick();
        checks++;
        if ({valid, RegWrite, createdump} !== 3'b000) begin
            errors++; $display("FAIL flush_bubble: got v%b rw%b dump%b, required 000", valid, RegWrite, createdump);
        end
        bubble();
        tick();
    endtask

    task automatic test_back_to_back();
        bubble();
        ex_valid = 1; ex_MemRead = 1; ex_XOut = 16'h0010; DC_Done = 0;
        tick();
        checks++;
        if ({stall_up, MemRead, XOut} !== {1'b1, 1'b1, 16'h0010}) begin
            errors++; $display("FAIL b2b_first: got stall%b rd%b x%h, required stall1 rd1 x0010", stall_up, MemRead, XOut);
        end
        ex_XOut = 16'h0020; DC_Done = 1;
        tick();
        DC_Done = 0;
        #1;
        checks++;
        if ({stall_up, MemRead, XOut} !== {1'b1, 1'b1, 16'h0020}) begin
            errors++; $display("FAIL b2b_second: got stall%b rd%b x%h, required stall1 rd1 x0020", stall_up, MemRead, XOut);
        end
        bubble();
        DC_Done = 1;
        tick();
        DC_Done = 0;
        #1;
        checks++;
        if ({stall_up, MemRead} !== 2'b00) begin
            errors++; $display("FAIL b2b_idle: got stall%b rd%b, required 00", stall_up, MemRead);
        end
    endtask

    task automatic test_mem_err_bubble();
        bubble();
        tick();
        DC_Done = 1;   // DC_Done while IDLE is ignored
        mem_err = 1;
        tick();
        mem_err = 0;
        DC_Done = 0;
        #1;
        checks++;
        if ({err, stall_up} !== 2'b00) begin
            errors++; $display("FAIL mem_err_bubble: got err%b stall%b, required 00", err, stall_up);
        end
    endtask

    task automatic test_watchdog();
        bubble();
        ex_valid = 1; ex_MemRead = 1; ex_XOut = 16'h0200; DC_Done = 0;
        tick();
        bubble();
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if ({err, stall_up} !== 2'b01) begin
                errors++; $display("FAIL wd_early_c%0d: got err%b stall%b, required err0 stall1", k, err, stall_up);
            end
        end
        tick();
        checks++;
        if ({err, stall_up} !== 2'b11) begin
            errors++; $display("FAIL wd_fire: got err%b stall%b, required err1 stall1", err, stall_up);
        end
        DC_Done = 1;
        tick();
        DC_Done = 0;
        repeat (2) tick();
        checks++;
        if ({err, stall_up} !== 2'b10) begin
            errors++; $display("FAIL wd_sticky: got err%b stall%b, required err1 stall0", err, stall_up);
        end
    endtask

    task automatic test_reset_mid_access();
        bubble();
        ex_valid = 1; ex_MemWrite = 1; ex_XOut = 16'h0300; ex_WriteData = 16'hCAFE; DC_Done = 0;
        tick();
        bubble();
        checks++;
        if ({MemWrite, stall_up} !== 2'b11) begin
            errors++; $display("FAIL rstmid_pre: got wr%b stall%b, required 11", MemWrite, stall_up);
        end
        #2 rst = 0;
        #1;
        checks++;
        if ({MemWrite, stall_up, err, XOut, WriteData} !== 35'b0) begin
            errors++; $display("FAIL rstmid_async: got wr%b stall%b err%b x%h wd%h, required all 0",
                               MemWrite, stall_up, err, XOut, WriteData);
        end
        #1 rst = 1;
        tick();
    endtask

    task automatic test_alignment();
        bubble();
        ex_valid = 1; ex_MemRead = 1; ex_RegWrite = 1; ex_XOut = 16'h0013; DC_Done = 0;
        tick();
        bubble();
`ifdef EX_MEM_ALIGN_CHECK_EN
        checks++;
        if ({MemRead, stall_up, RegWrite} !== 3'b000) begin
            errors++; $display("FAIL align_suppress: got rd%b stall%b rw%b, required 000", MemRead, stall_up, RegWrite);
        end
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL align_err: got %b, required 1", err);
        end
`else
        checks++;
        if ({MemRead, stall_up, XOut} !== {1'b1, 1'b1, 16'h0013}) begin
            errors++; $display("FAIL align_passthru: got rd%b stall%b x%h, required rd1 stall1 x0013", MemRead, stall_up, XOut);
        end
        DC_Done = 1;
        tick();
        DC_Done = 0;
        #1;
        checks++;
        if ({err, stall_up} !== 2'b00) begin
            errors++; $display("FAIL align_no_err: got err%b stall%b, required 00", err, stall_up);
        end
`endif
    endtask

    task automatic test_mem_err_valid();
        bubble();
        ex_valid = 1; ex_RegWrite = 1;
        tick();
        bubble();
        mem_err = 1;
        tick();
        mem_err = 0;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL mem_err_valid: got %b, required 1", err);
        end
    endtask

    initial begin
        test_reset();
        test_hit_load();
        test_miss_store();
        test_flush();
        test_back_to_back();
        test_mem_err_bubble();
        test_watchdog();
        test_reset_mid_access();
        test_alignment();
        pulse_reset();
        test_mem_err_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

EX/MEM pipeline register and access sequencer that sits directly upstream of the memory stage. It captures the execute-stage result, store data and control each cycle and presents them to the memory stage. While a data-cache access is outstanding, it holds those values and back-pressures the front of the pipe. It also runs a cache-access watchdog and merges memory-side errors into one sticky error flag.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles an access may remain outstanding before the watchdog fires; legal range 2..255.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a real instruction.
- ex_XOut  in  16  ALU result / effective address.
- ex_WriteData  in  16  store data.
- ex_MemRead, ex_MemWrite  in  1 each  memory op requests.
- ex_RegWrite, ex_MemToReg  in  1 each  writeback controls.
- ex_WriteReg  in  3  destination register.
- ex_halt  in  1  HALT; becomes createdump.
- flush  in  1  kill the incoming EX instruction.
- DC_Stall, DC_Done  in  1 each  from the memory stage.
- mem_err  in  1  err from the memory stage.
- XOut, WriteData  out  16 each  to the memory stage.
- MemRead, MemWrite, createdump  out  1 each  to the memory stage.
- RegWrite, MemToReg  out  1 each  forwarded to MEM/WB.
- WriteReg  out  3  forwarded to MEM/WB.
- valid  out  1  register holds a real instruction.
- stall_up  out  1  freeze IF/ID/EX this cycle.
- err  out  1  sticky error.

## Operation
- FSM states:
  - IDLE: no outstanding cache access.
  - ACCESS: a MemRead/MemWrite is outstanding.
- Load edge: any rising edge with stall_up=0. On a load edge the register captures all ex_* inputs.
  - If flush=1 or ex_valid=0, it captures a bubble: valid, MemRead, MemWrite, RegWrite, MemToReg and createdump are 0; data fields are don't-care but still loaded.
- stall_up = (state==ACCESS) & ~DC_Done. It is combinational; DC_Stall is only advisory and is not used for stall_up.
- IDLE→ACCESS on a load edge that captures valid & (ex_MemRead|ex_MemWrite).
- ACCESS→IDLE on the edge where DC_Done=1. That same edge is a load edge, so back-to-back memory ops go ACCESS→ACCESS with no idle cycle.
- MemRead/MemWrite outputs equal the latched bits ANDed with valid. They stay asserted and stable through ACCESS, and every output field is held constant while stall_up=1.
- Watchdog: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with DC_Done=0. When it reaches TIMEOUT, err sets. The FSM keeps waiting; it is not aborted.
- err sets on mem_err=1 while valid=1, or on watchdog expiry. err clears only on reset.
- flush during stall_up=1 has no effect; upstream holds it until the next load edge.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, watchdog=0, and all outputs 0, including XOut/WriteData=0x0000, WriteReg=0, err=0, stall_up=0.
- Latency: EX inputs appear on the outputs one cycle after a load edge.
- A cache hit with DC_Done in the first access cycle gives stall_up=0 throughout, so there is no bubble.
- A miss with DC_Done in access cycle N gives stall_up=1 for cycles 1..N-1.
- Reset asserted mid-ACCESS: the transaction is dropped immediately and outputs go to 0. The memory stage sees MemRead/MemWrite fall asynchronously.
- DC_Done while IDLE is ignored.

## Configuration
- EX_MEM_ALIGN_CHECK_EN defined:
  - A valid memory op with ex_XOut[0]=1 is captured with MemRead/MemWrite forced to 0, so the FSM stays IDLE.
  - err sets on the following edge.
  - RegWrite is forced to 0 for that instruction.
- Not defined: misaligned ops pass through unchanged and enter ACCESS normally. The memory stage's own alignment error reaches err via mem_err.

## Test plan
- Reset: hold rst=0 while driving ex_* non-zero -> every output reads 0 and stall_up=0; release -> first load on the next rising edge.
- Hit load: ex_MemRead=1, ex_XOut=0x0040, DC_Done=1 in the first cycle -> MemRead=1, XOut=0x0040 for one cycle, stall_up never 1, FSM back to IDLE.
- Miss store: ex_MemWrite=1, ex_WriteData=0xBEEF, DC_Done after 4 cycles -> stall_up=1 for 3 cycles, with WriteData=0xBEEF and MemWrite=1 stable throughout; the next EX instruction is loaded on the DC_Done edge.
- Flush: flush=1 with ex_valid=1 and ex_RegWrite=1 -> next cycle valid=0, RegWrite=0; flush pulsed during a stall -> no change to held outputs.
- Watchdog: TIMEOUT=8, DC_Done held 0 -> err rises after 8 ACCESS cycles and stays 1 after a later DC_Done until reset.
- Alignment: with EX_MEM_ALIGN_CHECK_EN, ex_MemRead=1 and ex_XOut=0x0013 -> MemRead=0, no stall, err=1 next edge; without the macro -> MemRead=1 and the FSM enters ACCESS.
